// File: rtl/nn_cfg_loader_pkg.sv
// Shared state encoding and cfg-port constants for the layer descriptor loader.
package nn_cfg_loader_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_CFG,
    S_START_SET,
    S_START_HOLD,
    S_START_CLR,
    S_WAIT_DONE,
    S_NEXT,
    S_FIN
  } state_e;

  localparam logic [2:0] CFG_ADDR_START  = 3'd6;
  localparam int         CFG_START_ON    = 1;
  localparam int         CFG_START_OFF   = 0;
  localparam int         DEF_DESC_WORDS  = 6;
  localparam int         DEF_DESC_STRIDE = 8;

endpackage

// File: rtl/nn_cfg_loader.sv
// Walks a DRAM descriptor table, writes each layer's cfg registers into the
// accelerator, pulses its start register and waits for layer completion.
//
// state        | meaning
// S_IDLE       | waiting for i_go
// S_RD_REQ     | one-cycle DMA read request for current descriptor word
// S_RD_WAIT    | read outstanding, waiting for i_dma_rd_ready
// S_WR_CFG     | write captured word to cfg register <word>
// S_START_SET  | write 1 to start register
// S_START_HOLD | start held high, down-counting the hold timer
// S_START_CLR  | write 0 to start register
// S_WAIT_DONE  | waiting for (or consuming a latched) layer done
// S_NEXT       | advance to next layer or finish
// S_FIN        | one-cycle done pulse
module nn_cfg_loader
  import nn_cfg_loader_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DESC_WORDS  = DEF_DESC_WORDS,
  parameter int DESC_STRIDE = DEF_DESC_STRIDE,
  parameter int START_HOLD  = 10,
  parameter int LAYER_W     = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_go,
  input  logic [ADDR_W-1:0]  i_desc_base,
  input  logic [LAYER_W-1:0] i_num_layers,
  output logic               o_dma_rd_en,
  output logic [ADDR_W-1:0]  o_dma_rd_addr,
  input  logic [DATA_W-1:0]  i_dma_rd_data,
  input  logic               i_dma_rd_ready,
  output logic [DATA_W-1:0]  o_cfg,
  output logic [2:0]         o_cfg_addr,
  output logic               o_cfg_wr_en,
  input  logic               i_layer_done,
  output logic               o_busy,
  output logic               o_done,
  output logic [LAYER_W-1:0] o_layer_idx
);

  localparam int HOLD_W = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [LAYER_W-1:0] num_q, num_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [2:0]         word_q, word_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               done_flag_q, done_flag_d;
  logic [DATA_W-1:0]  cfg_d;
  logic [2:0]         cfg_addr_d;
  logic [ADDR_W-1:0]  rd_addr_d;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    num_d       = num_q;
    layer_d     = layer_q;
    word_d      = word_q;
    hold_d      = hold_q;
    done_flag_d = done_flag_q;
    cfg_d       = '0;
    cfg_addr_d  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (i_go) begin
          base_d  = i_desc_base;
          num_d   = i_num_layers;
          layer_d = '0;
          word_d  = '0;
          state_d = (i_num_layers == '0) ? S_FIN : S_RD_REQ;
        end
      end
      S_RD_REQ:  state_d = S_RD_WAIT;
      S_RD_WAIT: if (i_dma_rd_ready) state_d = S_WR_CFG;
      S_WR_CFG: begin
        word_d  = word_q + 3'd1;
        state_d = (word_d == 3'(DESC_WORDS)) ? S_START_SET : S_RD_REQ;
      end
      S_START_SET: begin
        hold_d  = HOLD_W'(START_HOLD - 1);
        state_d = S_START_HOLD;
      end
      S_START_HOLD: begin
        if (hold_q == '0) state_d = S_START_CLR;
        else              hold_d  = hold_q - HOLD_W'(1);
      end
      S_START_CLR: state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (i_layer_done || done_flag_q) begin
          done_flag_d = 1'b0;
          layer_d     = layer_q + LAYER_W'(1);
          state_d     = S_NEXT;
        end
      end
      S_NEXT: begin
        word_d  = '0;
        state_d = (layer_q == num_q) ? S_FIN : S_RD_REQ;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A done that races the start pulse must not be lost.
    if (i_layer_done && (state_q inside {S_START_SET, S_START_HOLD, S_START_CLR}))
      done_flag_d = 1'b1;

    // Outputs are registered from the next state so they line up with it.
    unique case (state_d)
      S_WR_CFG: begin
        cfg_d      = i_dma_rd_data;
        cfg_addr_d = word_d;
      end
      S_START_SET: begin
        cfg_d      = DATA_W'(CFG_START_ON);
        cfg_addr_d = CFG_ADDR_START;
      end
      S_START_CLR: begin
        cfg_d      = DATA_W'(CFG_START_OFF);
        cfg_addr_d = CFG_ADDR_START;
      end
      default: ;
    endcase
  end

  assign rd_addr_d = base_d + ADDR_W'(layer_d) * ADDR_W'(DESC_STRIDE) + ADDR_W'(word_d);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      base_q        <= '0;
      num_q         <= '0;
      layer_q       <= '0;
      word_q        <= '0;
      hold_q        <= '0;
      done_flag_q   <= 1'b0;
      o_dma_rd_en   <= 1'b0;
      o_dma_rd_addr <= '0;
      o_cfg         <= '0;
      o_cfg_addr    <= '0;
      o_cfg_wr_en   <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_layer_idx   <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      num_q         <= num_d;
      layer_q       <= layer_d;
      word_q        <= word_d;
      hold_q        <= hold_d;
      done_flag_q   <= done_flag_d;
      o_dma_rd_en   <= (state_d == S_RD_REQ);
      o_dma_rd_addr <= (state_d == S_RD_REQ) ? rd_addr_d : '0;
      o_cfg         <= cfg_d;
      o_cfg_addr    <= cfg_addr_d;
      o_cfg_wr_en   <= (state_d inside {S_WR_CFG, S_START_SET, S_START_CLR});
      o_busy        <= !(state_d inside {S_IDLE, S_FIN});
      o_done        <= (state_d == S_FIN);
      o_layer_idx   <= layer_d;
    end
  end

endmodule
